// File: rtl/bulls_cows_pkg.sv
// Shared types for the Bulls & Cows board: game-state encoding (also used by the
// display driver), the four-digit BCD code type and the entry-validity rule.
package bulls_cows_pkg;

  localparam int DIGITS = 4;

  // Index 3 is the leftmost digit (switches[15:12]).
  typedef logic [DIGITS-1:0][3:0] code_t;

  typedef enum logic [2:0] {
    J1_SETUP = 3'b000,
    J2_SETUP = 3'b001,
    J1_GUESS = 3'b010,
    J2_GUESS = 3'b011,
    END_GAME = 3'b111
  } game_state_t;

  // A code is usable only if every digit is decimal and no digit repeats.
  function automatic logic is_valid_code(input code_t code);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (code[i] > 4'd9) ok = 1'b0;
      for (int j = i + 1; j < DIGITS; j++) begin
        if (code[i] == code[j]) ok = 1'b0;
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/bulls_cows_scorer.sv
// Combinational scorer: bulls are digits in the right place, cows are digits
// present in the secret at a different place.
module bulls_cows_scorer
  import bulls_cows_pkg::*;
(
  input  code_t      secret,
  input  code_t      guess,
  output logic [2:0] bulls,
  output logic [2:0] cows
);

  logic hit;

  // NOTE: every variable written here gets a value before any branch reads it;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    bulls = 3'd0;
    cows  = 3'd0;
    hit   = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      hit = 1'b0;
      for (int j = 0; j < DIGITS; j++) begin
        if (j != i && guess[i] == secret[j]) hit = 1'b1;
      end
      if (guess[i] == secret[i]) bulls = bulls + 3'd1;
      if (hit)                   cows  = cows + 3'd1;
    end
  end

endmodule

// File: rtl/bulls_cows_game_ctrl.sv
// Two-player Bulls & Cows sequencer: takes secrets and guesses on confirm,
// shows each score for a fixed hold time, then passes the turn or ends the round.
module bulls_cows_game_ctrl
  import bulls_cows_pkg::*;
#(
  parameter int RESULT_HOLD_CYCLES = 100_000_000,
  parameter int POINTS_MAX         = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        confirm,
  input  logic [15:0] switches,
  output logic [2:0]  game_state,
  output logic        guess_confirmed,
  output logic [2:0]  bull_count,
  output logic [2:0]  cow_count,
  output logic [7:0]  J1_points,
  output logic [7:0]  J2_points,
  output logic        input_error
);

  localparam int          HOLD_W    = $clog2(RESULT_HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RESULT_HOLD_CYCLES - 1);
  localparam logic [7:0]  PTS_MAX   = 8'(POINTS_MAX);

  game_state_t       state_q, state_d;
  code_t             secret1_q, secret1_d;
  code_t             secret2_q, secret2_d;
  logic [2:0]        bull_q, bull_d;
  logic [2:0]        cow_q, cow_d;
  logic              shown_q, shown_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [7:0]        j1_q, j1_d;
  logic [7:0]        j2_q, j2_d;
  logic              err_q, err_d;

  code_t      entry;
  code_t      target;
  logic       entry_ok;
  logic [2:0] score_bulls;
  logic [2:0] score_cows;

  assign entry    = code_t'(switches);
  assign entry_ok = is_valid_code(entry);
  // J1 attacks J2's secret and vice versa.
  assign target   = (state_q == J1_GUESS) ? secret2_q : secret1_q;

  bulls_cows_scorer u_scorer (
    .secret (target),
    .guess  (entry),
    .bulls  (score_bulls),
    .cows   (score_cows)
  );

  always_comb begin
    state_d   = state_q;
    secret1_d = secret1_q;
    secret2_d = secret2_q;
    bull_d    = bull_q;
    cow_d     = cow_q;
    shown_d   = shown_q;
    hold_d    = hold_q;
    j1_d      = j1_q;
    j2_d      = j2_q;
    err_d     = 1'b0;

    if (shown_q) begin
      // The turn outcome is applied only once the result has been displayed.
      if (hold_q == '0) begin
        shown_d = 1'b0;
        if (bull_q == 3'd4) begin
          state_d = END_GAME;
          if (state_q == J1_GUESS) j1_d = (j1_q == PTS_MAX) ? j1_q : j1_q + 8'd1;
          else                     j2_d = (j2_q == PTS_MAX) ? j2_q : j2_q + 8'd1;
        end else begin
          state_d = (state_q == J1_GUESS) ? J2_GUESS : J1_GUESS;
        end
      end else begin
        hold_d = hold_q - 1'b1;
      end
    end else if (confirm) begin
      if (state_q == END_GAME) begin
        state_d   = J1_SETUP;
        secret1_d = '0;
        secret2_d = '0;
        bull_d    = 3'd0;
        cow_d     = 3'd0;
      end else if (!entry_ok) begin
        err_d = 1'b1;
      end else begin
        case (state_q)
          J1_SETUP: begin
            secret1_d = entry;
            state_d   = J2_SETUP;
          end
          J2_SETUP: begin
            secret2_d = entry;
            state_d   = J1_GUESS;
          end
          J1_GUESS, J2_GUESS: begin
            bull_d  = score_bulls;
            cow_d   = score_cows;
            shown_d = 1'b1;
            hold_d  = HOLD_LOAD;
          end
          default: state_d = J1_SETUP;
        endcase
      end
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples the
  // values from before the edge, independent of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= J1_SETUP;
      secret1_q <= '0;
      secret2_q <= '0;
      bull_q    <= 3'd0;
      cow_q     <= 3'd0;
      shown_q   <= 1'b0;
      hold_q    <= '0;
      j1_q      <= 8'd0;
      j2_q      <= 8'd0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      secret1_q <= secret1_d;
      secret2_q <= secret2_d;
      bull_q    <= bull_d;
      cow_q     <= cow_d;
      shown_q   <= shown_d;
      hold_q    <= hold_d;
      j1_q      <= j1_d;
      j2_q      <= j2_d;
      err_q     <= err_d;
    end
  end

  assign game_state      = state_q;
  assign guess_confirmed = shown_q;
  assign bull_count      = bull_q;
  assign cow_count       = cow_q;
  assign J1_points       = j1_q;
  assign J2_points       = j2_q;
  assign input_error     = err_q;

endmodule

// File: tb/tb_bulls_cows_game_ctrl.sv
// Self-checking bench for bulls_cows_game_ctrl: directed game scenarios followed
// by random play, compared every cycle against a digit-level game model.
module tb_bulls_cows_game_ctrl;

  localparam int H = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        confirm;
  logic [15:0] switches;
  logic [2:0]  game_state;
  logic        guess_confirmed;
  logic [2:0]  bull_count;
  logic [2:0]  cow_count;
  logic [7:0]  J1_points;
  logic [7:0]  J2_points;
  logic        input_error;

  bulls_cows_game_ctrl #(.RESULT_HOLD_CYCLES(H), .POINTS_MAX(255)) dut (
    .clock           (clock),
    .reset           (reset),
    .confirm         (confirm),
    .switches        (switches),
    .game_state      (game_state),
    .guess_confirmed (guess_confirmed),
    .bull_count      (bull_count),
    .cow_count       (cow_count),
    .J1_points       (J1_points),
    .J2_points       (J2_points),
    .input_error     (input_error)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Game model: phase 0..4 = J1 setup, J2 setup, J1 guess, J2 guess, end.
  int          m_phase;
  logic [15:0] m_sec1, m_sec2;
  int          m_bulls, m_cows, m_j1, m_j2, m_hold;
  bit          m_shown, m_err;

  function automatic int digit(input logic [15:0] c, input int i);
    return int'((c >> (4 * i)) & 16'hF);
  endfunction

  function automatic bit valid(input logic [15:0] c);
    bit seen [16];
    foreach (seen[k]) seen[k] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (digit(c, i) > 9) return 1'b0;
      if (seen[digit(c, i)]) return 1'b0;
      seen[digit(c, i)] = 1'b1;
    end
    return 1'b1;
  endfunction

  task automatic score(input logic [15:0] s, input logic [15:0] g, output int b, output int c);
    b = 0;
    c = 0;
    for (int i = 0; i < 4; i++) begin
      bit found = 1'b0;
      if (digit(g, i) == digit(s, i)) b++;
      for (int j = 0; j < 4; j++) if (j != i && digit(g, i) == digit(s, j)) found = 1'b1;
      if (found) c++;
    end
  endtask

  function automatic logic [2:0] phase_enc(input int p);
    case (p)
      0: return 3'b000;
      1: return 3'b001;
      2: return 3'b010;
      3: return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

  function automatic logic [15:0] rand_valid();
    int d [10];
    logic [15:0] code;
    for (int i = 0; i < 10; i++) d[i] = i;
    for (int i = 9; i > 0; i--) begin
      int j = int'($urandom_range(i, 0));
      int t = d[i];
      d[i] = d[j];
      d[j] = t;
    end
    code = 16'h0;
    for (int i = 0; i < 4; i++) code = code | (16'(d[i]) << (4 * i));
    return code;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_sec1 = 16'h0; m_sec2 = 16'h0;
    m_bulls = 0; m_cows = 0; m_j1 = 0; m_j2 = 0;
    m_hold = 0; m_shown = 1'b0; m_err = 1'b0;
  endtask

  // One clock of the game as seen by the players.
  task automatic model_step(input bit conf, input logic [15:0] code);
    m_err = 1'b0;
    if (m_shown) begin
      if (m_hold == 1) begin
        m_shown = 1'b0;
        if (m_bulls == 4) begin
          if (m_phase == 2) m_j1 = (m_j1 < 255) ? m_j1 + 1 : 255;
          else              m_j2 = (m_j2 < 255) ? m_j2 + 1 : 255;
          m_phase = 4;
        end else begin
          m_phase = (m_phase == 2) ? 3 : 2;
        end
      end else begin
        m_hold--;
      end
    end else if (conf) begin
      if (m_phase == 4) begin
        m_phase = 0; m_sec1 = 16'h0; m_sec2 = 16'h0; m_bulls = 0; m_cows = 0;
      end else if (!valid(code)) begin
        m_err = 1'b1;
      end else if (m_phase == 0) begin
        m_sec1 = code; m_phase = 1;
      end else if (m_phase == 1) begin
        m_sec2 = code; m_phase = 2;
      end else begin
        score((m_phase == 2) ? m_sec2 : m_sec1, code, m_bulls, m_cows);
        m_shown = 1'b1;
        m_hold  = H;
      end
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    check("game_state", {5'b0, game_state}, {5'b0, phase_enc(m_phase)});
    check("guess_confirmed", {7'b0, guess_confirmed}, {7'b0, m_shown});
    check("bull_count", {5'b0, bull_count}, 8'(m_bulls));
    check("cow_count", {5'b0, cow_count}, 8'(m_cows));
    check("J1_points", J1_points, 8'(m_j1));
    check("J2_points", J2_points, 8'(m_j2));
    check("input_error", {7'b0, input_error}, {7'b0, m_err});
  endtask

  // Called at a falling edge; drives one cycle and checks at the next falling edge.
  task automatic cycle(input bit conf, input logic [15:0] code);
    switches = code;
    confirm  = conf;
    @(posedge clock);
    model_step(conf, code);
    @(negedge clock);
    confirm = 1'b0;
    check_all();
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 16'($urandom));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic j1_win_game();
    cycle(1'b1, 16'h1234);
    cycle(1'b1, 16'h5678);
    cycle(1'b1, 16'h5678);
    idle(H);
    cycle(1'b1, 16'h0000);
  endtask

  int r;

  initial begin
    reset    = 1'b1;
    confirm  = 1'b0;
    switches = 16'h0;
    model_reset();
    @(negedge clock);
    do_reset();

    // Rejected entries in J1 setup.
    cycle(1'b1, 16'h1123);
    check("err_repeat_digit", {7'b0, input_error}, 8'd1);
    idle(1);
    cycle(1'b1, 16'h12A4);
    check("err_non_bcd", {7'b0, input_error}, 8'd1);
    check("setup_state_kept", {5'b0, game_state}, 8'h00);
    idle(1);

    // Secrets.
    cycle(1'b1, 16'h1234);
    check("to_j2_setup", {5'b0, game_state}, 8'h01);
    cycle(1'b1, 16'h5678);
    check("to_j1_guess", {5'b0, game_state}, 8'h02);

    // J1 guess 5687 vs 5678.
    cycle(1'b1, 16'h5687);
    check("g1_bulls", {5'b0, bull_count}, 8'd2);
    check("g1_cows", {5'b0, cow_count}, 8'd2);
    check("g1_shown", {7'b0, guess_confirmed}, 8'd1);
    idle(3);
    cycle(1'b1, 16'h1234);
    idle(H);
    check("g1_turn_passed", {5'b0, game_state}, 8'h03);

    // J2 guess 9012 vs 1234, with an ignored confirm during the hold.
    cycle(1'b1, 16'h9012);
    check("g2_bulls", {5'b0, bull_count}, 8'd0);
    check("g2_cows", {5'b0, cow_count}, 8'd2);
    cycle(1'b1, 16'h5678);
    check("g2_no_rescore", {5'b0, bull_count}, 8'd0);
    idle(H);
    check("g2_turn_passed", {5'b0, game_state}, 8'h02);

    // J1 wins.
    cycle(1'b1, 16'h5678);
    check("win_bulls", {5'b0, bull_count}, 8'd4);
    idle(H);
    check("win_end_state", {5'b0, game_state}, 8'h07);
    check("win_point", J1_points, 8'd1);
    cycle(1'b1, 16'hFFFF);
    check("end_to_setup", {5'b0, game_state}, 8'h00);
    check("end_no_error", {7'b0, input_error}, 8'd0);
    check("points_kept", J1_points, 8'd1);

    // Reset in the middle of a winning hold.
    cycle(1'b1, 16'h1234);
    cycle(1'b1, 16'h5678);
    cycle(1'b1, 16'h5678);
    idle(3);
    do_reset();
    check("abort_no_point", J1_points, 8'd0);

    // Random play.
    repeat (400) begin
      r = int'($urandom_range(9, 0));
      if (r < 5)      cycle(1'b0, 16'($urandom));
      else if (r < 7) cycle(1'b1, 16'($urandom));
      else if (r < 9) cycle(1'b1, rand_valid());
      else            cycle(1'b1, (m_phase == 3) ? m_sec1 : m_sec2);
    end

    // Saturation of J1 points.
    do_reset();
    repeat (256) j1_win_game();
    check("j1_saturated", J1_points, 8'd255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
